// File: rtl/spi_reg_bank.sv
// SPI register bank: address byte (bit7 = write), then data byte(s); outputs are all registered.
// Define SPI_REG_BURST_EN to auto-increment the address on every data byte and stay in DATA.
module spi_reg_bank #(
    parameter logic [7:0] FPGA_VER = 8'hC2
) (
    input  logic       clk_core,
    input  logic       reset,
    input  logic       transaction_begin,
    input  logic       rx_byte_available,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    output logic       bootloader_force,
    output logic [7:0] uart_inverted,
    output logic [7:0] telemetry_con_sel,
    output logic       wr_strobe
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state_reg;
    logic [6:0] addr_reg;
    logic       rw_reg;
    logic [7:0] tx_byte_reg;
    logic       bootloader_force_reg;
    logic [7:0] uart_inverted_reg;
    logic [7:0] telemetry_con_sel_reg;
    logic [7:0] scratch_reg;
    logic [7:0] err_cnt_reg;
    logic       wr_strobe_reg;

    // Input register, two-sample history, registered edge: byte acted on 3 edges after it is seen.
    logic avail_reg;
    logic avail_cur_reg;
    logic avail_prev_reg;
    logic byte_edge_reg;
    logic byte_edge;
    logic addr_writable;

    assign byte_edge     = avail_cur_reg & ~avail_prev_reg;
    assign addr_writable = (addr_reg >= 7'd1) && (addr_reg <= 7'd4);

`ifdef SPI_REG_BURST_EN
    logic [6:0] addr_next;
    assign addr_next = addr_reg + 7'd1;
`endif

    function automatic logic [7:0] read_value(input logic [6:0] a);
        case (a)
            7'h00:   return FPGA_VER;
            7'h01:   return {7'b0, bootloader_force_reg};
            7'h02:   return uart_inverted_reg;
            7'h03:   return telemetry_con_sel_reg;
            7'h04:   return scratch_reg;
            7'h05:   return err_cnt_reg;
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk_core) begin
        if (reset) begin
            state_reg             <= IDLE;
            addr_reg              <= 7'd0;
            rw_reg                <= 1'b0;
            tx_byte_reg           <= 8'h00;
            bootloader_force_reg  <= 1'b0;
            uart_inverted_reg     <= 8'h00;
            telemetry_con_sel_reg <= 8'h00;
            scratch_reg           <= 8'h00;
            err_cnt_reg           <= 8'h00;
            wr_strobe_reg         <= 1'b0;
            avail_reg             <= 1'b0;
            avail_cur_reg         <= 1'b0;
            avail_prev_reg        <= 1'b0;
            byte_edge_reg         <= 1'b0;
        end else begin
            avail_reg      <= rx_byte_available;
            avail_cur_reg  <= avail_reg;
            avail_prev_reg <= avail_cur_reg;
            byte_edge_reg  <= byte_edge;
            wr_strobe_reg  <= 1'b0;

            // A new transaction wins over any byte landing in the same cycle.
            if (transaction_begin) begin
                state_reg   <= ADDR;
                tx_byte_reg <= 8'h00;
            end else if (byte_edge_reg) begin
                case (state_reg)
                    ADDR: begin
                        addr_reg  <= rx_byte[6:0];
                        rw_reg    <= rx_byte[7];
                        state_reg <= DATA;
                        if (!rx_byte[7]) begin
                            tx_byte_reg <= read_value(rx_byte[6:0]);
                        end
                    end
                    DATA: begin
                        if (rw_reg) begin
                            if (addr_writable) begin
                                case (addr_reg)
                                    7'h01:   bootloader_force_reg  <= rx_byte[0];
                                    7'h02:   uart_inverted_reg     <= rx_byte;
                                    7'h03:   telemetry_con_sel_reg <= rx_byte;
                                    7'h04:   scratch_reg           <= rx_byte;
                                    default: ;
                                endcase
                                wr_strobe_reg <= 1'b1;
                            end else if (err_cnt_reg != 8'hFF) begin
                                err_cnt_reg <= err_cnt_reg + 8'd1;
                            end
                        end
`ifdef SPI_REG_BURST_EN
                        addr_reg <= addr_next;
                        if (!rw_reg) begin
                            tx_byte_reg <= read_value(addr_next);
                        end
`else
                        state_reg   <= IDLE;
                        tx_byte_reg <= 8'h00;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tx_byte           = tx_byte_reg;
    assign bootloader_force  = bootloader_force_reg;
    assign uart_inverted     = uart_inverted_reg;
    assign telemetry_con_sel = telemetry_con_sel_reg;
    assign wr_strobe         = wr_strobe_reg;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed cases plus random transactions against a
// behavioural model of the register map; honours SPI_REG_BURST_EN when defined.
module tb_spi_reg_bank;

    logic       clk_core = 1'b0;
    logic       reset = 1'b1;
    logic       transaction_begin = 1'b0;
    logic       rx_byte_available = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] tx_byte;
    logic       bootloader_force;
    logic [7:0] uart_inverted;
    logic [7:0] telemetry_con_sel;
    logic       wr_strobe;

    spi_reg_bank #(.FPGA_VER(8'hC2)) dut (
        .clk_core          (clk_core),
        .reset             (reset),
        .transaction_begin (transaction_begin),
        .rx_byte_available (rx_byte_available),
        .rx_byte           (rx_byte),
        .tx_byte           (tx_byte),
        .bootloader_force  (bootloader_force),
        .uart_inverted     (uart_inverted),
        .telemetry_con_sel (telemetry_con_sel),
        .wr_strobe         (wr_strobe)
    );

    always #10 clk_core = ~clk_core;

    int checks = 0;
    int failures = 0;
    int strobe_seen = 0;
    int strobe_expected = 0;

    always @(posedge clk_core) begin
        if (wr_strobe === 1'b1) strobe_seen++;
    end

    // Behavioural model: memory image of the map, error counter, transaction phase.
    logic [7:0] m_reg [0:127];
    logic [7:0] m_err;
    int         m_phase;   // 0 = no transaction, 1 = expecting address, 2 = expecting data
    int         m_addr;
    logic       m_rw;
    logic [7:0] m_tx;
    logic       m_pulse;

    function automatic logic [7:0] m_read(input int a);
        if (a == 5) return m_err;
        return m_reg[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 128; i++) m_reg[i] = 8'h00;
        m_reg[0] = 8'hC2;
        m_err    = 8'h00;
        m_phase  = 0;
        m_addr   = 0;
        m_rw     = 1'b0;
        m_tx     = 8'h00;
        m_pulse  = 1'b0;
    endtask

    task automatic m_begin();
        m_phase = 1;
        m_tx    = 8'h00;
        m_pulse = 1'b0;
    endtask

    task automatic m_byte(input logic [7:0] b);
        m_pulse = 1'b0;
        if (m_phase == 1) begin
            m_addr  = int'(b) % 128;
            m_rw    = b[7];
            m_phase = 2;
            if (!m_rw) m_tx = m_read(m_addr);
        end else if (m_phase == 2) begin
            if (m_rw) begin
                if (m_addr >= 1 && m_addr <= 4) begin
                    m_reg[m_addr] = (m_addr == 1) ? {7'b0, b[0]} : b;
                    m_pulse = 1'b1;
                    strobe_expected++;
                end else if (m_err != 8'hFF) begin
                    m_err = m_err + 8'd1;
                end
            end
`ifdef SPI_REG_BURST_EN
            m_addr = (m_addr + 1) % 128;
            if (!m_rw) m_tx = m_read(m_addr);
`else
            m_phase = 0;
            m_tx    = 8'h00;
`endif
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_tx"}, tx_byte, m_tx);
        chk({tag, "_boot"}, {7'b0, bootloader_force}, {7'b0, m_reg[1][0]});
        chk({tag, "_uart"}, uart_inverted, m_reg[2]);
        chk({tag, "_tel"}, telemetry_con_sel, m_reg[3]);
    endtask

    task automatic do_reset();
        @(negedge clk_core);
        reset = 1'b1;
        repeat (2) @(negedge clk_core);
        reset = 1'b0;
        m_reset();
        chk_outputs("reset");
        chk("reset_strobe", {7'b0, wr_strobe}, 8'h00);
        $display("reset applied");
    endtask

    task automatic begin_txn();
        @(negedge clk_core);
        transaction_begin = 1'b1;
        @(negedge clk_core);
        transaction_begin = 1'b0;
        m_begin();
        chk("begin_tx", tx_byte, m_tx);
    endtask

    // Byte first seen at edge E0; DUT must change outputs at E3 and not before.
    task automatic send_byte(input logic [7:0] b, input bit coincide);
        @(negedge clk_core);
        rx_byte           = b;
        rx_byte_available = 1'b1;
        repeat (3) @(posedge clk_core);
        #1;
        chk("latency_hold", tx_byte, m_tx);
        if (coincide) transaction_begin = 1'b1;
        @(posedge clk_core);
        #1;
        transaction_begin = 1'b0;
        if (coincide) m_begin();
        else m_byte(b);
        chk_outputs("byte");
        chk("strobe", {7'b0, wr_strobe}, {7'b0, m_pulse});
        @(negedge clk_core);
        rx_byte_available = 1'b0;
        repeat (3) @(negedge clk_core);
        chk("strobe_width", {7'b0, wr_strobe}, 8'h00);
        $display("byte 0x%02h coincide=%0d tx=0x%02h uart=0x%02h tel=0x%02h boot=%0d",
                 b, coincide, tx_byte, uart_inverted, telemetry_con_sel, bootloader_force);
    endtask

    initial begin
        m_reset();
        do_reset();

        // Bytes with no open transaction are ignored.
        send_byte(8'h84, 1'b0);
        send_byte(8'h33, 1'b0);
        chk("idle_ignore_tx", tx_byte, 8'h00);

        // Version register read.
        begin_txn();
        send_byte(8'h00, 1'b0);
        chk("ver_read", tx_byte, 8'hC2);
        send_byte(8'h00, 1'b0);

        // Bootloader force write and read-back.
        begin_txn();
        send_byte(8'h81, 1'b0);
        send_byte(8'h01, 1'b0);
        chk("boot_set", {7'b0, bootloader_force}, 8'h01);
        begin_txn();
        send_byte(8'h01, 1'b0);
        chk("boot_read", tx_byte, 8'h01);

        // Write to read-only register: no effect, error counted, counter saturates.
        begin_txn();
        send_byte(8'h80, 1'b0);
        send_byte(8'h55, 1'b0);
        begin_txn();
        send_byte(8'h00, 1'b0);
        chk("ro_unchanged", tx_byte, 8'hC2);
        begin_txn();
        send_byte(8'h05, 1'b0);
        chk("err_one", tx_byte, 8'h01);
        for (int i = 0; i < 300; i++) begin
            begin_txn();
            send_byte(8'h80, 1'b0);
            send_byte(8'h55, 1'b0);
        end
        begin_txn();
        send_byte(8'h05, 1'b0);
        chk("err_sat", tx_byte, 8'hFF);

        // Multi-byte write starting at 0x02.
        begin_txn();
        send_byte(8'h82, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h77, 1'b0);
        chk("burst_uart", uart_inverted, 8'hA5);
        begin_txn();
        send_byte(8'h04, 1'b0);
`ifdef SPI_REG_BURST_EN
        chk("burst_tel", telemetry_con_sel, 8'h3C);
        chk("burst_scratch", tx_byte, 8'h77);
`else
        chk("single_tel", telemetry_con_sel, 8'h00);
        chk("single_scratch", tx_byte, 8'h00);
`endif

        // Read from the top of the address space.
        begin_txn();
        send_byte(8'h7F, 1'b0);
        chk("read_7f", tx_byte, 8'h00);
        send_byte(8'h00, 1'b0);
`ifdef SPI_REG_BURST_EN
        chk("wrap_read", tx_byte, 8'hC2);
`else
        chk("after_data_tx", tx_byte, 8'h00);
`endif

        // transaction_begin coincident with a byte: byte dropped, bank waits for an address.
        begin_txn();
        send_byte(8'h02, 1'b0);
        send_byte(8'h84, 1'b1);
        chk("coincide_tx", tx_byte, 8'h00);
        send_byte(8'h00, 1'b0);
        chk("coincide_addr", tx_byte, 8'hC2);

        // Reset between address and data of a scratch write.
        begin_txn();
        send_byte(8'h84, 1'b0);
        do_reset();
        send_byte(8'h99, 1'b0);
        begin_txn();
        send_byte(8'h04, 1'b0);
        chk("reset_scratch", tx_byte, 8'h00);

        // Random transactions.
        for (int t = 0; t < 60; t++) begin
            logic [7:0] ab;
            int nb;
            ab[7]   = 1'($urandom_range(0, 1));
            ab[6:0] = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 6));
            nb = $urandom_range(0, 3);
            begin_txn();
            send_byte(ab, 1'b0);
            for (int k = 0; k < nb; k++) send_byte(8'($urandom), 1'b0);
        end

        // Final register image read-back.
        for (int a = 0; a < 6; a++) begin
            begin_txn();
            send_byte(8'(a), 1'b0);
            chk("final_read", tx_byte, m_read(a));
        end

        repeat (3) @(negedge clk_core);
        checks++;
        assert (strobe_seen == strobe_expected)
        else begin
            failures++;
            $error("FAIL strobe_count observed=%0d expected=%0d", strobe_seen, strobe_expected);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL have parameter FPGA_VER, default 8'hC2, meaning value returned from register 0x00.
REQ-002 SHALL have port clk_core  input  1  system clock, 50 MHz, all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port transaction_begin  input  1  one-cycle pulse from the SPI slave when SS asserts.
REQ-005 SHALL have port rx_byte_available  input  1  level from the SPI slave; a rising edge marks a new byte.
REQ-006 SHALL have port rx_byte  input  8  received byte, stable while rx_byte_available is high.
REQ-007 SHALL have port tx_byte  output  8  byte presented to the SPI slave for the next shift-out.
REQ-008 SHALL have port bootloader_force  output  1  pin forcing the flight controller to stay in its bootloader.
REQ-009 SHALL have port uart_inverted  output  8  per-UART inversion enables.
REQ-010 SHALL have port telemetry_con_sel  output  8  telemetry connector select.
REQ-011 SHALL have port wr_strobe  output  1  one-cycle pulse on every accepted register write.

Function
REQ-012 SHALL detect byte edges with a 2-flop history of rx_byte_available; edge = current sample 1 and previous sample 0.
REQ-013 SHALL act on a byte exactly 3 clk_core edges after rx_byte_available is first high at a rising edge; tx_byte and register updates are visible at that edge.
REQ-014 SHALL implement states IDLE, ADDR and DATA; after reset the state is IDLE.
REQ-015 SHALL, on transaction_begin in any state: enter ADDR and set tx_byte to 0x00.
REQ-016 SHALL, in IDLE, ignore byte edges.
REQ-017 SHALL, on an edge in ADDR: latch addr = rx_byte[6:0] and rw = rx_byte[7] (0 = read, 1 = write), then enter DATA.
REQ-018 SHALL, if rw = 0 in ADDR, load tx_byte with the contents of addr at the same edge.
REQ-019 SHALL, on an edge in DATA with rw = 1: write rx_byte to addr if addr is writable, and pulse wr_strobe for 1 cycle.
REQ-020 SHALL implement this register map.
- 0x00: RO, returns FPGA_VER.
- 0x01: RW, bit0 = bootloader_force; bits 7:1 read as 0.
- 0x02: RW, uart_inverted.
- 0x03: RW, telemetry_con_sel.
- 0x04: RW, scratch.
- 0x05: RO, err_cnt.
REQ-021 SHALL read any unmapped address as 0x00 and ignore writes to it.
REQ-022 SHALL, on a write to a RO or unmapped address: suppress wr_strobe and increment err_cnt, which saturates at 0xFF and does not wrap.
REQ-023 SHALL, when transaction_begin and a byte edge occur in the same cycle, give transaction_begin priority and drop the byte.
REQ-024 SHALL drive outputs directly from registers, with no combinational path from input to output.

Reset
REQ-025 SHALL, while reset is high: force state IDLE, tx_byte 0x00, bootloader_force 0, uart_inverted 0x00, telemetry_con_sel 0x00, scratch 0x00, err_cnt 0x00 and wr_strobe 0.
REQ-026 SHALL, when reset occurs mid-transaction, abandon the transaction; bytes after reset are ignored until the next transaction_begin.

Configuration
REQ-027 SHALL, with macro SPI_REG_BURST_EN defined: on each DATA edge, increment addr modulo 128 (0x7F wraps to 0x00) after the access. For reads, tx_byte is loaded with the new addr at the same edge. The bank stays in DATA until transaction_begin or reset.
REQ-028 SHALL, without SPI_REG_BURST_EN: return to IDLE after the first DATA edge and set tx_byte to 0x00. Further bytes are ignored until transaction_begin.

Verification
REQ-029 SHALL cover this case: reset, transaction_begin, byte 0x00 -> tx_byte = 0xC2 exactly 3 cycles after the edge.
REQ-030 SHALL cover this case: transaction_begin, bytes 0x81 then 0x01 -> bootloader_force = 1 and one wr_strobe pulse. A following read of 0x01 returns 0x01.
REQ-031 SHALL cover this case: write 0x55 to 0x00 -> register 0x00 still reads 0xC2, err_cnt reads 0x01 and no wr_strobe. After 300 such writes, err_cnt = 0xFF.
REQ-032 SHALL cover this case: with SPI_REG_BURST_EN defined, bytes 0x82, 0xA5, 0x3C, 0x77 -> uart_inverted = 0xA5, telemetry_con_sel = 0x3C, scratch = 0x77. A burst read from 0x7F returns 0x00 then 0xC2 (wrap). Without the macro, only 0xA5 is written.
REQ-033 SHALL cover this case: transaction_begin coincident with a byte edge -> byte dropped and state ADDR.
REQ-034 SHALL cover this case: reset pulsed between the address and data bytes of a write to 0x04 -> scratch = 0x00, and the data byte is ignored.
